axis_eth_fcs_check: RTL and testbench

Receive-side counterpart to the FCS generator: accepts an 8-bit AXI4-Stream Ethernet frame with its 4-byte FCS trailer and checks the CRC-32. It strips the FCS and forwards the payload with tlast, and flags bad frames on tuser. It sits between the MAC receive path and the frame consumer, using a 4-byte delay line so the trailer is never forwarded.

---
 rtl/eth_fcs_pkg.sv | 15 +
 rtl/axis_eth_fcs_check_if.sv | 15 +
 rtl/lfsr.sv | 49 ++++
 rtl/axis_eth_fcs_check.sv | 114 +++++++++++
 tb/tb_axis_eth_fcs_check.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/eth_fcs_pkg.sv
// Shared constants for the Ethernet FCS (CRC-32) generator and checker.
package eth_fcs_pkg;

  localparam logic [31:0] CRC_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
  localparam int          FCS_LEN     = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_STREAM
  } fill_state_t;

endpackage

// File: rtl/axis_eth_fcs_check_if.sv
// Byte-wide AXI4-Stream bundle; master drives data, slave drives tready.
interface axis_eth_fcs_check_if #(
  parameter int DATA_WIDTH = 8
);

  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic                  tuser;

  modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
  modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);

endinterface

// File: rtl/lfsr.sv
// Combinational Galois LFSR/CRC step: advances state_in by DATA_WIDTH input bits.
module lfsr #(
  parameter int                    LFSR_WIDTH        = 32,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY         = 32'h04C11DB7,
  parameter string                 LFSR_CONFIG       = "GALOIS",
  parameter bit                    LFSR_FEED_FORWARD = 1'b0,
  parameter bit                    REVERSE           = 1'b1,
  parameter int                    DATA_WIDTH        = 8
) (
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [LFSR_WIDTH-1:0] state_in,
  output logic [LFSR_WIDTH-1:0] state_out
);

  function automatic logic [LFSR_WIDTH-1:0] bit_rev(input logic [LFSR_WIDTH-1:0] v);
    logic [LFSR_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < LFSR_WIDTH; i++) r[i] = v[LFSR_WIDTH-1-i];
    return r;
  endfunction

  localparam logic [LFSR_WIDTH-1:0] POLY_REV = bit_rev(LFSR_POLY);

  if (LFSR_CONFIG != "GALOIS" || LFSR_FEED_FORWARD) begin : g_bad_cfg
    $error("lfsr: only the Galois form without feed-forward is implemented");
  end

  logic [LFSR_WIDTH-1:0] st;
  logic                  fb;

  // REVERSE shifts LSB-first through a reflected register (Ethernet bit order)
  always_comb begin
    st = state_in;
    fb = 1'b0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (REVERSE) begin
        fb = st[0] ^ data_in[i];
        st = st >> 1;
        if (fb) st = st ^ POLY_REV;
      end else begin
        fb = st[LFSR_WIDTH-1] ^ data_in[DATA_WIDTH-1-i];
        st = st << 1;
        if (fb) st = st ^ LFSR_POLY;
      end
    end
    state_out = st;
  end

endmodule

// File: rtl/axis_eth_fcs_check.sv
// Receive FCS checker: strips the 4-byte trailer through a delay line and flags bad frames.
// Optional AXIS_ETH_FCS_CHECK_COUNT_EN adds a saturating bad_frame_count output.
//
// state  | meaning
// IDLE   | delay line empty (count 0), waiting for first byte of a frame
// FILL   | 1..3 bytes held, nothing released yet
// STREAM | 4 bytes held; each new byte pushes the oldest to the output
module axis_eth_fcs_check
  import eth_fcs_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  axis_eth_fcs_check_if.slave  s_axis,
  axis_eth_fcs_check_if.master m_axis,
  output logic                 error_bad_fcs,
  output logic                 error_short_frame
`ifdef AXIS_ETH_FCS_CHECK_COUNT_EN
  ,
  output logic [15:0]          bad_frame_count
`endif
);

  if (DATA_WIDTH != 8) begin : g_bad_width
    $error("axis_eth_fcs_check: DATA_WIDTH must be 8");
  end

  fill_state_t state;
  logic [2:0]  count, count_next;
  logic [31:0] crc, crc_next;
  logic [31:0] dly;
  logic        frame_user;
  logic        accept, load_out, short_hit, fcs_bad, frame_bad;

  assign s_axis.tready = !m_axis.tvalid || m_axis.tready;
  assign accept        = s_axis.tvalid && s_axis.tready;
  assign fcs_bad       = crc_next != CRC_RESIDUE;
  assign frame_bad     = frame_user || s_axis.tuser || fcs_bad;

  lfsr #(
    .LFSR_WIDTH       (32),
    .LFSR_POLY        (CRC_POLY),
    .LFSR_CONFIG      ("GALOIS"),
    .LFSR_FEED_FORWARD(1'b0),
    .REVERSE          (1'b1),
    .DATA_WIDTH       (8)
  ) u_crc (
    .data_in  (s_axis.tdata),
    .state_in (crc),
    .state_out(crc_next)
  );

  always_ff @(posedge clk) begin
    if (rst) count <= '0;
    else     count <= count_next;
  end

  always_comb begin
    state      = ST_FILL;
    count_next = count;
    load_out   = 1'b0;
    short_hit  = 1'b0;
    if (count == '0)               state = ST_IDLE;
    else if (count == 3'(FCS_LEN)) state = ST_STREAM;
    if (accept) begin
      load_out  = (state == ST_STREAM);
      short_hit = s_axis.tlast && (state != ST_STREAM);
      if (s_axis.tlast)             count_next = '0;
      else if (state != ST_STREAM)  count_next = count + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dly               <= '0;
      crc               <= CRC_INIT;
      frame_user        <= 1'b0;
      m_axis.tdata      <= '0;
      m_axis.tvalid     <= 1'b0;
      m_axis.tlast      <= 1'b0;
      m_axis.tuser      <= 1'b0;
      error_bad_fcs     <= 1'b0;
      error_short_frame <= 1'b0;
    end else begin
      error_bad_fcs     <= load_out && s_axis.tlast && fcs_bad;
      error_short_frame <= short_hit;
      if (accept) begin
        dly        <= {dly[23:0], s_axis.tdata};
        crc        <= s_axis.tlast ? CRC_INIT : crc_next;
        frame_user <= s_axis.tlast ? 1'b0 : (frame_user || s_axis.tuser);
      end
      // a reload can coincide with a drain, so tvalid simply stays high
      if (load_out) begin
        m_axis.tdata  <= dly[31:24];
        m_axis.tvalid <= 1'b1;
        m_axis.tlast  <= s_axis.tlast;
        m_axis.tuser  <= s_axis.tlast && frame_bad;
      end else if (m_axis.tready) begin
        m_axis.tvalid <= 1'b0;
      end
    end
  end

`ifdef AXIS_ETH_FCS_CHECK_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      bad_frame_count <= '0;
    else if ((short_hit || (load_out && s_axis.tlast && frame_bad)) && bad_frame_count != 16'hFFFF)
      bad_frame_count <= bad_frame_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_axis_eth_fcs_check.sv
// Self-checking bench for axis_eth_fcs_check: directed table, reset cases and random frames.
module tb_axis_eth_fcs_check;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axis_eth_fcs_check_if s_if ();
  axis_eth_fcs_check_if m_if ();
  logic error_bad_fcs, error_short_frame;
`ifdef AXIS_ETH_FCS_CHECK_COUNT_EN
  logic [15:0] bad_frame_count;
`endif

  axis_eth_fcs_check dut (
    .clk              (clk),
    .rst              (rst),
    .s_axis           (s_if),
    .m_axis           (m_if),
    .error_bad_fcs    (error_bad_fcs),
    .error_short_frame(error_short_frame)
`ifdef AXIS_ETH_FCS_CHECK_COUNT_EN
    ,
    .bad_frame_count  (bad_frame_count)
`endif
  );

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic       user;
  } beat_t;

  typedef struct {
    string name;
    int    kind;
    int    corrupt;
    int    uidx;
    int    reps;
    bit    bp;
    bit    exp_user;
    int    exp_bad;
    int    exp_short;
  } vec_t;

  beat_t obs_q[$];
  beat_t exp_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    bad_pulses = 0, short_pulses = 0;
  int    exp_bad_total = 0, exp_short_total = 0, exp_badcnt = 0;
  bit    bp_en = 1'b0;
  bit    stall_prev = 1'b0;
  beat_t stall_beat;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // reference CRC-32 as transmitted in the Ethernet FCS (final value inverted)
  function automatic logic [31:0] crc32(input logic [7:0] p[$]);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (p[i]) begin
      c = c ^ {24'h0, p[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic void model(input logic [7:0] b[$], input bit u[$]);
    int          n;
    bit          anyu, bad;
    logic [7:0]  pay[$];
    logic [31:0] fcs;
    beat_t       e;
    n    = b.size();
    anyu = 1'b0;
    foreach (u[i]) anyu |= u[i];
    if (n <= 4) begin
      exp_short_total++;
      exp_badcnt++;
      return;
    end
    for (int i = 0; i < n - 4; i++) pay.push_back(b[i]);
    fcs = {b[n-1], b[n-2], b[n-3], b[n-4]};
    bad = crc32(pay) != fcs;
    for (int i = 0; i < n - 4; i++) begin
      e.data = pay[i];
      e.last = (i == n - 5);
      e.user = (i == n - 5) && (anyu || bad);
      exp_q.push_back(e);
    end
    if (bad) exp_bad_total++;
    if (anyu || bad) exp_badcnt++;
  endfunction

  initial begin
    m_if.tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_if.tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  always @(negedge clk) begin
    beat_t b;
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      b = '{m_if.tdata, m_if.tlast, m_if.tuser};
      if (stall_prev) check("hold_stable", 32'({m_if.tvalid, b}), 32'({1'b1, stall_beat}));
      stall_prev = m_if.tvalid && !m_if.tready;
      stall_beat = b;
      if (m_if.tvalid && m_if.tready) obs_q.push_back(b);
      if (error_bad_fcs) begin
        bad_pulses++;
        check("bad_fcs_with_tlast", 32'({m_if.tvalid, m_if.tlast}), 32'h3);
      end
      if (error_short_frame) short_pulses++;
    end
  end

  task automatic send_frame(input logic [7:0] b[$], input bit u[$], input bit with_last, input int gap);
    int budget;
    bit acc;
    for (int i = 0; i < b.size(); i++) begin
      while (gap > 0 && int'($urandom_range(0, 99)) < gap) begin
        s_if.tvalid = 1'b0;
        @(posedge clk);
        #1;
      end
      s_if.tdata  = b[i];
      s_if.tvalid = 1'b1;
      s_if.tlast  = with_last && (i == b.size() - 1);
      s_if.tuser  = u[i];
      budget = 100;
      acc    = 1'b0;
      while (!acc && budget > 0) begin
        @(negedge clk);
        acc = s_if.tready;
        @(posedge clk);
        #1;
        budget--;
      end
      if (!acc) begin
        check("accept_timeout", 32'd0, 32'd1);
        break;
      end
    end
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    s_if.tuser  = 1'b0;
  endtask

  task automatic drain();
    int budget;
    budget = 400;
    while ((obs_q.size() < exp_q.size() || m_if.tvalid) && budget > 0) begin
      @(posedge clk);
      #1;
      budget--;
    end
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    if (budget == 0) check("drain_timeout", 32'd0, 32'd1);
  endtask

  task automatic compare_queues(input string tag);
    int n;
    check({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({tag, "_beat"}, 32'(obs_q[i]), 32'(exp_q[i]));
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic reset_chk(input string tag);
    @(negedge clk);
    check({tag, "_tvalid"}, 32'(m_if.tvalid), 32'd0);
    check({tag, "_tlast"},  32'(m_if.tlast),  32'd0);
    check({tag, "_tuser"},  32'(m_if.tuser),  32'd0);
    check({tag, "_tdata"},  32'(m_if.tdata),  32'd0);
    check({tag, "_errs"},   32'({error_bad_fcs, error_short_frame}), 32'd0);
    check({tag, "_sready"}, 32'(s_if.tready), 32'd1);
`ifdef AXIS_ETH_FCS_CHECK_COUNT_EN
    check({tag, "_count"},  32'(bad_frame_count), 32'd0);
`endif
  endtask

  task automatic build(input int kind, input int corrupt, input int uidx,
                       output logic [7:0] b[$], output bit u[$]);
    logic [31:0] f;
    b.delete();
    u.delete();
    case (kind)
      0: b = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
               8'h26, 8'h39, 8'hF4, 8'hCB};
      1: b = '{8'hAA, 8'hBB, 8'hCC};
      default: begin
        for (int i = 0; i < 60; i++) b.push_back(8'(i));
        f = crc32(b);
        for (int i = 0; i < 4; i++) b.push_back(f[8*i +: 8]);
      end
    endcase
    if (corrupt != 0) b[b.size()-1] = b[b.size()-1] ^ 8'h01;
    foreach (b[i]) u.push_back(i == uidx);
  endtask

  vec_t vecs[6];

  initial begin
    logic [7:0]  fb[$];
    bit          fu[$];
    logic [31:0] f;
    int          b0, s0, len;

    vecs[0] = '{"good",         0, 0, -1, 1, 1'b0, 1'b0, 0, 0};
    vecs[1] = '{"bad_fcs",      0, 1, -1, 1, 1'b0, 1'b1, 1, 0};
    vecs[2] = '{"b2b_bp",       2, 0, -1, 2, 1'b1, 1'b0, 0, 0};
    vecs[3] = '{"upstream_err", 0, 0,  2, 1, 1'b0, 1'b1, 0, 0};
    vecs[4] = '{"short",        1, 0, -1, 1, 1'b0, 1'b0, 0, 1};
    vecs[5] = '{"good_after",   0, 0, -1, 1, 1'b0, 1'b0, 0, 0};

    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    s_if.tuser  = 1'b0;
    s_if.tdata  = '0;
    repeat (3) @(posedge clk);
    #1;
    reset_chk("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // reset in the middle of a frame, then a clean frame
    build(2, 0, -1, fb, fu);
    fb = fb[0:19];
    fu = fu[0:19];
    send_frame(fb, fu, 1'b0, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    reset_chk("mid_reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    obs_q.delete();
    bad_pulses = 0;
    short_pulses = 0;
    build(0, 0, -1, fb, fu);
    model(fb, fu);
    send_frame(fb, fu, 1'b1, 0);
    drain();
    check("after_reset_bytes", 32'(obs_q.size()), 32'd9);
    compare_queues("after_reset");

    for (int v = 0; v < 6; v++) begin
      b0 = bad_pulses;
      s0 = short_pulses;
      bp_en = vecs[v].bp;
      for (int r = 0; r < vecs[v].reps; r++) begin
        build(vecs[v].kind, vecs[v].corrupt, vecs[v].uidx, fb, fu);
        model(fb, fu);
        send_frame(fb, fu, 1'b1, 0);
      end
      drain();
      bp_en = 1'b0;
      if (obs_q.size() > 0) check({vecs[v].name, "_user"}, 32'(obs_q[$].user), 32'(vecs[v].exp_user));
      check({vecs[v].name, "_bad_pulse"},   32'(bad_pulses - b0),   32'(vecs[v].exp_bad * vecs[v].reps));
      check({vecs[v].name, "_short_pulse"}, 32'(short_pulses - s0), 32'(vecs[v].exp_short * vecs[v].reps));
      compare_queues(vecs[v].name);
    end

    for (int g = 0; g < 6; g++) begin
      bp_en = 1'($urandom_range(0, 1));
      for (int k = 0; k < 5; k++) begin
        fb.delete();
        fu.delete();
        len = int'($urandom_range(0, 30));
        for (int i = 0; i < len; i++) fb.push_back(8'($urandom));
        f = crc32(fb);
        for (int i = 0; i < 4; i++) fb.push_back(f[8*i +: 8]);
        if ($urandom_range(0, 99) < 30) fb[$urandom_range(0, fb.size()-1)] ^= 8'(1 << $urandom_range(0, 7));
        foreach (fb[i]) fu.push_back(1'b0);
        if ($urandom_range(0, 99) < 20) fu[$urandom_range(0, fu.size()-1)] = 1'b1;
        model(fb, fu);
        send_frame(fb, fu, 1'b1, 20);
      end
      drain();
      bp_en = 1'b0;
      compare_queues("random");
    end

    check("bad_pulse_total",   32'(bad_pulses),   32'(exp_bad_total));
    check("short_pulse_total", 32'(short_pulses), 32'(exp_short_total));
`ifdef AXIS_ETH_FCS_CHECK_COUNT_EN
    check("bad_frame_count", 32'(bad_frame_count), 32'(exp_badcnt));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
